ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 20 ++
 rtl/ram.sv | 30 +++
 rtl/ram_arbiter.sv | 93 +++++++++
 tb/tb_ram_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and the round-robin pick rule for the two-requester RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned RAM_ADDR_W = 9;
    localparam int unsigned RAM_DATA_W = 32;

    typedef logic req_id_t;

    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

    // Winner among the current requesters; on contention the one not granted last wins.
    function automatic req_id_t rr_pick(input logic m0_req, input logic m1_req, input req_id_t last);
        if (m0_req && m1_req) begin
            return (last == REQ_M0) ? REQ_M1 : REQ_M0;
        end
        return m1_req ? REQ_M1 : REQ_M0;
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM: write and registered read both take effect on the rising edge.
module ram
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wEn,
    input  logic [DATA_W-1:0] wDat,
    input  logic              rEn,
    output logic [DATA_W-1:0] rDat
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents deliberately have no reset.
    always_ff @(posedge clock) begin
        if (wEn) begin
            mem[addr] <= wDat;
        end
        if (rEn) begin
            rDat <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between two requesters, one access per cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata
);

    req_id_t           last_q;
    req_id_t           pick_c;
    logic              accept_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    logic              cmd_wen_q;
    logic              cmd_ren_q;
    req_id_t           cmd_id_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] ram_rdata;

    // Grant is combinational; reset_n gates it so nothing is granted while held in reset.
    always_comb begin
        pick_c      = rr_pick(m0_req, m1_req, last_q);
        m0_gnt      = reset_n && m0_req && (pick_c == REQ_M0);
        m1_gnt      = reset_n && m1_req && (pick_c == REQ_M1);
        accept_c    = m0_gnt || m1_gnt;
        sel_we_c    = (pick_c == REQ_M1) ? m1_we    : m0_we;
        sel_addr_c  = (pick_c == REQ_M1) ? m1_addr  : m0_addr;
        sel_wdata_c = (pick_c == REQ_M1) ? m1_wdata : m0_wdata;
    end

    // Command register feeding the RAM one cycle after acceptance; rvalid follows the RAM read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= REQ_M1;
            cmd_wen_q   <= 1'b0;
            cmd_ren_q   <= 1'b0;
            cmd_id_q    <= REQ_M0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
        end else begin
            cmd_wen_q <= accept_c && sel_we_c;
            cmd_ren_q <= accept_c && !sel_we_c;
            if (accept_c) begin
                last_q      <= pick_c;
                cmd_id_q    <= pick_c;
                cmd_addr_q  <= sel_addr_c;
                cmd_wdata_q <= sel_wdata_c;
            end
            m0_rvalid <= cmd_ren_q && (cmd_id_q == REQ_M0);
            m1_rvalid <= cmd_ren_q && (cmd_id_q == REQ_M1);
        end
    end

    ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .addr  (cmd_addr_q),
        .wEn   (cmd_wen_q),
        .wDat  (cmd_wdata_q),
        .rEn   (cmd_ren_q),
        .rDat  (ram_rdata)
    );

    assign m0_rdata = ram_rdata;
    assign m1_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: queued requester agents, a transaction-level memory model and in-order read expectations.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [8:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [8:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;

    ram_arbiter dut (
        .clock (clock), .reset_n (reset_n),
        .m0_req (m0_req), .m0_we (m0_we), .m0_addr (m0_addr), .m0_wdata (m0_wdata),
        .m0_gnt (m0_gnt), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata),
        .m1_req (m1_req), .m1_we (m1_we), .m1_addr (m1_addr), .m1_wdata (m1_wdata),
        .m1_gnt (m1_gnt), .m1_rvalid (m1_rvalid), .m1_rdata (m1_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          due;
        bit          id;
        bit          chk;
        logic [31:0] data;
    } pend_t;

    cmd_t        q0[$], q1[$];
    pend_t       pq[$];
    logic [31:0] mref [512];
    bit          known [512];
    bit          act0 = 0, act1 = 0;
    bit          idle_en = 0;
    int          last = 1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic we, input logic [8:0] addr, input logic [31:0] wdata);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.wdata = wdata;
        return c;
    endfunction

    task automatic accept(input bit id, input cmd_t c);
        pend_t p;
        if (c.we) begin
            mref[c.addr] = c.wdata;
            known[c.addr] = 1'b1;
        end else begin
            p.due = cyc + 2;
            p.id = id;
            p.chk = known[c.addr];
            p.data = mref[c.addr];
            pq.push_back(p);
        end
    endtask

    // One clock cycle: drive held requests, check at the falling edge, update the model.
    task automatic step();
        bit e0, e1, r0, r1;
        if (!act0 && q0.size() > 0) act0 = idle_en ? ($urandom_range(3) != 0) : 1'b1;
        if (!act1 && q1.size() > 0) act1 = idle_en ? ($urandom_range(3) != 0) : 1'b1;
        m0_req = act0;
        m1_req = act1;
        if (act0) begin
            m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end else begin
            m0_we = 1'($urandom); m0_addr = 9'($urandom); m0_wdata = $urandom;
        end
        if (act1) begin
            m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end else begin
            m1_we = 1'($urandom); m1_addr = 9'($urandom); m1_wdata = $urandom;
        end
        @(negedge clock);
        if (!reset_n) begin
            e0 = 0; e1 = 0;
        end else if (act0 && act1) begin
            e0 = (last == 1); e1 = !e0;
        end else begin
            e0 = act0; e1 = act1;
        end
        check("m0_gnt", 32'(m0_gnt), 32'(e0));
        check("m1_gnt", 32'(m1_gnt), 32'(e1));
        r0 = 0; r1 = 0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            if (pq[0].id) r1 = 1; else r0 = 1;
        end
        check("m0_rvalid", 32'(m0_rvalid), 32'(r0));
        check("m1_rvalid", 32'(m1_rvalid), 32'(r1));
        if (r0 || r1) begin
            if (pq[0].chk) check(r1 ? "m1_rdata" : "m0_rdata", r1 ? m1_rdata : m0_rdata, pq[0].data);
            void'(pq.pop_front());
        end
        if (e0) begin accept(0, q0.pop_front()); act0 = 0; last = 0; end
        if (e1) begin accept(1, q1.pop_front()); act1 = 0; last = 1; end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q0.size() + q1.size() + pq.size()) > 0; i++) step();
        check("drain_left", 32'(q0.size() + q1.size() + pq.size()), 32'd0);
        step();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        pq.delete();
        last = 1;
        for (int i = 0; i < n; i++) step();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset with both requesters already asking: no grants until release.
        q0.push_back(mk(1'b1, 9'h010, 32'hA5A5_0010));
        q1.push_back(mk(1'b1, 9'h020, 32'h5A5A_0020));
        do_reset(3);
        drain();

        // Single write then read from requester 0.
        q0.push_back(mk(1'b1, 9'h005, 32'hDEAD_BEEF));
        step();
        q0.push_back(mk(1'b0, 9'h005, 32'h0));
        drain();

        // Contention straight out of reset: m0 first, then strict alternation.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 9'h010, 32'h0));
            q1.push_back(mk(1'b0, 9'h020, 32'h0));
        end
        drain();

        // Write by m1 followed next cycle by read of the same address from m0.
        q1.push_back(mk(1'b1, 9'h1FF, 32'h1234_5678));
        step();
        q0.push_back(mk(1'b0, 9'h1FF, 32'h0));
        drain();

        // Back-to-back reads from m0.
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, 9'(i), $urandom));
        drain();
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 9'(i), 32'h0));
        drain();

        // Random mixed traffic with idle gaps; 0x005 is left untouched.
        idle_en = 1;
        for (int i = 0; i < 120; i++) begin
            cmd_t c;
            c = mk(1'($urandom), 9'($urandom_range(9'h1FF, 9'h040)), $urandom);
            if ($urandom_range(1) == 1) q1.push_back(c); else q0.push_back(c);
        end
        drain();
        idle_en = 0;

        // Reset while an m1 read is in flight: the read must vanish, RAM must keep its data.
        q1.push_back(mk(1'b0, 9'h005, 32'h0));
        step();
        do_reset(2);
        for (int i = 0; i < 4; i++) step();
        q0.push_back(mk(1'b0, 9'h005, 32'h0));
        drain();
        check("ram_keep_005", mref[9'h005], 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
